// File: rtl/uzorak_punjac_pkg.sv
// Shared constants and state encoding for the sonar sample feeder and the
// classifier neurons that consume the assembled feature vector.
package uzorak_punjac_pkg;

  localparam int N_ZNACAJKI = 60;
  localparam int SIRINA     = 16;
  localparam int UZORAK_W   = N_ZNACAJKI * SIRINA;
  localparam int INDEKS_W   = $clog2(N_ZNACAJKI);

  typedef enum logic [1:0] {
    PUNJENJE = 2'd0,
    CEKANJE  = 2'd1,
    IZLAZ    = 2'd2
  } stanje_t;

endpackage

// File: rtl/uzorak_punjac.sv
// Assembles a serial stream of feature words into one sample vector, holds it
// for the classifier latency, then hands the captured class out over valid/ready.
module uzorak_punjac
  import uzorak_punjac_pkg::*;
#(
  parameter int LATENCIJA = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SIRINA-1:0]   in_podatak,
  input  logic                in_valid,
  input  logic                in_zadnji,
  output logic                in_ready,
  output logic [UZORAK_W-1:0] uzorak,
  input  logic                ind_1,
  input  logic                ind_2,
  output logic                rez_valid,
  input  logic                rez_ready,
  output logic [1:0]          rez_klasa,
  output logic                greska,
  output logic [15:0]         broj_uzoraka
);

  // A zero-latency classifier still needs a one-bit counter that is always 0.
  localparam int CEK_W = (LATENCIJA > 0) ? $clog2(LATENCIJA + 1) : 1;
  localparam logic [CEK_W-1:0]    CEK_POC    = CEK_W'(LATENCIJA);
  localparam logic [INDEKS_W-1:0] ZADNJI_IDX = INDEKS_W'(N_ZNACAJKI - 1);

  stanje_t               r_stanje;
  logic [INDEKS_W-1:0]   r_indeks;
  logic [CEK_W-1:0]      r_cekanje;
  logic                  r_in_ready;
  logic                  r_rez_valid;
  logic [1:0]            r_rez_klasa;
  logic                  r_greska;
  logic [15:0]           r_broj;
  logic [UZORAK_W-1:0]   r_uzorak;

  stanje_t               w_stanje_next;
  logic [INDEKS_W-1:0]   w_indeks_next;
  logic [CEK_W-1:0]      w_cekanje_next;
  logic                  w_rez_valid_next;
  logic [1:0]            w_rez_klasa_next;
  logic                  w_greska_next;
  logic [15:0]           w_broj_next;
  logic                  w_upis;
  logic                  w_prihvat;

  assign w_prihvat = in_valid && r_in_ready;

  always_comb begin
    w_stanje_next    = r_stanje;
    w_indeks_next    = r_indeks;
    w_cekanje_next   = r_cekanje;
    w_rez_valid_next = r_rez_valid;
    w_rez_klasa_next = r_rez_klasa;
    w_greska_next    = 1'b0;
    w_broj_next      = r_broj;
    w_upis           = 1'b0;
    case (r_stanje)
      PUNJENJE: begin
        if (w_prihvat) begin
          if (r_indeks == ZADNJI_IDX) begin
            w_indeks_next = '0;
            if (in_zadnji) begin
              w_upis         = 1'b1;
              w_cekanje_next = CEK_POC;
              w_stanje_next  = CEKANJE;
            end else begin
              w_greska_next = 1'b1;
            end
          end else if (in_zadnji) begin
            // Short frame: drop it; stale words get overwritten by the next sample.
            w_indeks_next = '0;
            w_greska_next = 1'b1;
          end else begin
            w_upis        = 1'b1;
            w_indeks_next = r_indeks + INDEKS_W'(1);
          end
        end
      end
      CEKANJE: begin
        if (r_cekanje == '0) begin
          w_rez_klasa_next = {ind_2, ind_1};
          w_rez_valid_next = 1'b1;
          w_stanje_next    = IZLAZ;
        end else begin
          w_cekanje_next = r_cekanje - CEK_W'(1);
        end
      end
      IZLAZ: begin
        if (r_rez_valid && rez_ready) begin
          w_rez_valid_next = 1'b0;
          w_broj_next      = r_broj + 16'd1;
          w_stanje_next    = PUNJENJE;
        end
      end
      default: w_stanje_next = PUNJENJE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stanje    <= PUNJENJE;
      r_indeks    <= '0;
      r_cekanje   <= '0;
      r_in_ready  <= 1'b0;
      r_rez_valid <= 1'b0;
      r_rez_klasa <= 2'b00;
      r_greska    <= 1'b0;
      r_broj      <= 16'd0;
    end else begin
      r_stanje    <= w_stanje_next;
      r_indeks    <= w_indeks_next;
      r_cekanje   <= w_cekanje_next;
      // Registered so it stays low for the whole first cycle after reset.
      r_in_ready  <= (w_stanje_next == PUNJENJE);
      r_rez_valid <= w_rez_valid_next;
      r_rez_klasa <= w_rez_klasa_next;
      r_greska    <= w_greska_next;
      r_broj      <= w_broj_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uzorak <= '0;
    end else begin
      for (int k = 0; k < N_ZNACAJKI; k++) begin
        if (w_upis && (r_indeks == INDEKS_W'(k))) begin
          r_uzorak[k*SIRINA +: SIRINA] <= in_podatak;
        end
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign uzorak       = r_uzorak;
  assign rez_valid    = r_rez_valid;
  assign rez_klasa    = r_rez_klasa;
  assign greska       = r_greska;
  assign broj_uzoraka = r_broj;

endmodule
